// File: rtl/player_mover_if.sv
// ----------------------------------------------------------------------------
// player_mover_if
//   Groups the signals exchanged between the player mover and its
//   surroundings.
//   Inputs to the mover:
//     - the four raw buttons
//     - win / game_over fed back from the collision checker
//     - the VGA timing counters xCount / yCount
//   Outputs from the mover:
//     - the per-pixel player flag
//     - the registered position player_x / player_y
//     - the frozen status
//   The master drives the mover's inputs (timing, collision checker, buttons).
//   The slave side is the mover itself.
// ----------------------------------------------------------------------------
interface player_mover_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       win;
   logic       game_over;
   logic [9:0] xCount;
   logic [9:0] yCount;
   logic       player;
   logic [9:0] player_x;
   logic [9:0] player_y;
   logic       frozen;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, win, game_over, xCount, yCount,
      input  player, player_x, player_y, frozen
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, win, game_over, xCount, yCount,
      output player, player_x, player_y, frozen
   );
endinterface

// File: rtl/player_mover.sv
// ----------------------------------------------------------------------------
// player_mover
//   Owns the player's top-left position.
//   Moves are paced by a tick divider and are committed only during vertical
//   blanking, so a frame never shows a half-moved square.
//   Freezes permanently (until reset) once win or game_over is seen.
// Ports
//   clk  : system clock
//   rst  : synchronous, active-low reset
//   bus  : player_mover_if.slave
//          inputs : buttons, win, game_over, xCount, yCount
//          outputs: player, player_x, player_y, frozen
// ----------------------------------------------------------------------------
module player_mover #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int SIZE     = 10,
   parameter int STEP     = 2,
   parameter int START_X  = 20,
   parameter int START_Y  = 20,
   parameter int TICK_DIV = 250000
) (
   input  logic           clk,
   input  logic           rst,
   player_mover_if.slave  bus
);

   localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [10:0]     STEP_W    = 11'(STEP);
   localparam logic [10:0]     SIZE_W    = 11'(SIZE);
   localparam logic [10:0]     X_MAX     = 11'(H_ACTIVE - SIZE);
   localparam logic [10:0]     Y_MAX     = 11'(V_ACTIVE - SIZE);
   localparam logic [9:0]      V_ACT_W   = 10'(V_ACTIVE);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_FROZEN  = 2'd2
   } state_t;

   // One axis step: dec/inc held together cancel; the sum is formed in 11 bits
   // and clamped to [0, max_pos] so the position can never wrap.
   function automatic logic [9:0] move_axis(input logic [9:0]  pos,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [10:0] max_pos);
      logic [10:0] p;
      logic [10:0] sum;
      logic [9:0]  r;
      p   = {1'b0, pos};
      sum = p + STEP_W;
      if (dec && !inc) begin
         if (p < STEP_W) begin
            r = 10'd0;
         end else begin
            r = 10'(p - STEP_W);
         end
      end else if (inc && !dec) begin
         if (sum > max_pos) begin
            r = 10'(max_pos);
         end else begin
            r = 10'(sum);
         end
      end else begin
         r = pos;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [3:0]       btn_meta_q, btn_meta_d;   // {up, down, left, right}
   logic [3:0]       btn_sync_q, btn_sync_d;
   logic [9:0]       player_x_q, player_x_d;
   logic [9:0]       player_y_q, player_y_d;
   logic             frozen_q, frozen_d;

   logic             tick_s;
   logic             freeze_s;
   logic             blank_s;
   logic             commit_s;

   assign tick_s   = (tick_cnt_q == TICK_LAST);
   assign freeze_s = bus.win | bus.game_over;
   assign blank_s  = (bus.yCount >= V_ACT_W);

   // Two-flop synchronizers for the raw buttons.
   always_comb begin
      btn_meta_d = {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
      btn_sync_d = btn_meta_q;
   end

   // Tick divider: free-running wrap counter, held while frozen.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (state_q == ST_FROZEN) begin
         tick_cnt_d = tick_cnt_q;
      end else if (tick_s) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
   end

   // FSM next state; freeze wins over both tick and commit.
   always_comb begin
      state_d  = state_q;
      commit_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (freeze_s) begin
               state_d = ST_FROZEN;
            end else if (tick_s && (btn_sync_q != 4'b0000)) begin
               state_d = ST_PENDING;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PENDING: begin
            // Ticks are ignored here: at most one move per blanking interval.
            if (freeze_s) begin
               state_d = ST_FROZEN;
            end else if (blank_s) begin
               state_d  = ST_IDLE;
               commit_s = 1'b1;
            end else begin
               state_d = ST_PENDING;
            end
         end
         ST_FROZEN: begin
            state_d = ST_FROZEN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Position update: direction comes from the buttons at the commit cycle.
   always_comb begin
      player_x_d = player_x_q;
      player_y_d = player_y_q;
      if (commit_s) begin
         player_y_d = move_axis(player_y_q, btn_sync_q[3], btn_sync_q[2], Y_MAX);
         player_x_d = move_axis(player_x_q, btn_sync_q[1], btn_sync_q[0], X_MAX);
      end else begin
         player_x_d = player_x_q;
         player_y_d = player_y_q;
      end
   end

   // Sticky freeze flag, one cycle behind win|game_over.
   always_comb begin
      frozen_d = frozen_q | freeze_s;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         btn_meta_q <= 4'b0000;
         btn_sync_q <= 4'b0000;
         player_x_q <= 10'(START_X);
         player_y_q <= 10'(START_Y);
         frozen_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         btn_meta_q <= btn_meta_d;
         btn_sync_q <= btn_sync_d;
         player_x_q <= player_x_d;
         player_y_q <= player_y_d;
         frozen_q   <= frozen_d;
      end
   end

   // Pixel flag is combinational from the registers so it stays aligned with
   // the rest of the pixel pipeline; 11-bit compares avoid overflow at the edge.
   assign bus.player = ({1'b0, bus.xCount} >= {1'b0, player_x_q}) &&
                       ({1'b0, bus.xCount} <  ({1'b0, player_x_q} + SIZE_W)) &&
                       ({1'b0, bus.yCount} >= {1'b0, player_y_q}) &&
                       ({1'b0, bus.yCount} <  ({1'b0, player_y_q} + SIZE_W));

   assign bus.player_x = player_x_q;
   assign bus.player_y = player_y_q;
   assign bus.frozen   = frozen_q;

endmodule

// File: tb/tb_player_mover.sv
// ----------------------------------------------------------------------------
// tb_player_mover
//   Three instances share one clock and reset:
//     u_dut : start (20,20)
//     u_lo  : start (1,20), for the left clamp
//     u_hi  : start (629,20), for the right clamp
//   Expected positions are pushed to a queue when a move is requested and
//   popped once the commit edge has passed.
// ----------------------------------------------------------------------------
module tb_player_mover;

   localparam int TD = 4;

   typedef struct {
      int sel;
      int x;
      int y;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   mx[3];
   int   my[3];
   exp_t sb[$];

   always #5 clk = ~clk;

   player_mover_if if_m ();
   player_mover_if if_lo ();
   player_mover_if if_hi ();

   player_mover #(.TICK_DIV(TD)) u_dut (.clk(clk), .rst(rst), .bus(if_m));
   player_mover #(.TICK_DIV(TD), .START_X(1)) u_lo (.clk(clk), .rst(rst), .bus(if_lo));
   player_mover #(.TICK_DIV(TD), .START_X(629)) u_hi (.clk(clk), .rst(rst), .bus(if_hi));

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Button vector order: {up, down, left, right}
   task automatic set_btn(input int sel, input logic [3:0] b);
      case (sel)
         0: {if_m.btn_up, if_m.btn_down, if_m.btn_left, if_m.btn_right} = b;
         1: {if_lo.btn_up, if_lo.btn_down, if_lo.btn_left, if_lo.btn_right} = b;
         default: {if_hi.btn_up, if_hi.btn_down, if_hi.btn_left, if_hi.btn_right} = b;
      endcase
   endtask

   task automatic set_xy(input int x, input int y);
      if_m.xCount  = 10'(x);
      if_m.yCount  = 10'(y);
      if_lo.xCount = 10'(x);
      if_lo.yCount = 10'(y);
      if_hi.xCount = 10'(x);
      if_hi.yCount = 10'(y);
   endtask

   function automatic int st(input int sel);
      logic [1:0] s;
      case (sel)
         0:       s = u_dut.state_q;
         1:       s = u_lo.state_q;
         default: s = u_hi.state_q;
      endcase
      return int'(s);
   endfunction

   function automatic int px(input int sel);
      case (sel)
         0:       return int'(if_m.player_x);
         1:       return int'(if_lo.player_x);
         default: return int'(if_hi.player_x);
      endcase
   endfunction

   function automatic int py(input int sel);
      case (sel)
         0:       return int'(if_m.player_y);
         1:       return int'(if_lo.player_y);
         default: return int'(if_hi.player_y);
      endcase
   endfunction

   // Reference step: cancel on both, clamp to [0, lim].
   function automatic int ref_step(input int p, input bit dec, input bit inc, input int lim);
      if (dec && !inc) return (p - 2 < 0) ? 0 : p - 2;
      if (inc && !dec) return (p + 2 > lim) ? lim : p + 2;
      return p;
   endfunction

   task automatic reset_models();
      mx[0] = 20;  my[0] = 20;
      mx[1] = 1;   my[1] = 20;
      mx[2] = 629; my[2] = 20;
   endtask

   // Hold buttons until PENDING, present blanking for one edge, check result.
   task automatic do_move(input int sel, input logic [3:0] b, input string tag);
      int   n;
      exp_t e;
      set_btn(sel, b);
      set_xy(0, 0);
      repeat (3) @(negedge clk);
      n = 0;
      while (st(sel) != 1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_pending"}, st(sel), 1);
      check_val({tag, "_x_before"}, px(sel), mx[sel]);
      e.sel = sel;
      e.y = ref_step(my[sel], b[3], b[2], 470);
      e.x = ref_step(mx[sel], b[1], b[0], 630);
      sb.push_back(e);
      mx[sel] = e.x;
      my[sel] = e.y;
      set_xy(0, 480);
      @(negedge clk);
      e = sb.pop_front();
      check_val({tag, "_x"}, px(e.sel), e.x);
      check_val({tag, "_y"}, py(e.sel), e.y);
      check_val({tag, "_idle"}, st(e.sel), 0);
      set_xy(0, 0);
      set_btn(sel, 4'b0000);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      set_btn(0, 4'b0000);
      set_btn(1, 4'b0000);
      set_btn(2, 4'b0000);
      if_m.win = 1'b0;  if_m.game_over = 1'b0;
      if_lo.win = 1'b0; if_lo.game_over = 1'b0;
      if_hi.win = 1'b0; if_hi.game_over = 1'b0;
      set_xy(0, 0);
      reset_models();
      repeat (2) @(negedge clk);

      // Reset state
      check_val("rst_x", px(0), 20);
      check_val("rst_y", py(0), 20);
      check_val("rst_frozen", int'(if_m.frozen), 0);
      check_val("rst_state", st(0), 0);
      check_val("rst_player_off", int'(if_m.player), 0);
      set_xy(20, 20);
      #1;
      check_val("rst_player_on", int'(if_m.player), 1);
      rst = 1'b1;
      set_xy(0, 0);
      @(negedge clk);

      // Single right move, then up+down+left (vertical cancels)
      do_move(0, 4'b0001, "right");
      do_move(0, 4'b1110, "udl");

      // Horizontal clamps at both edges
      do_move(1, 4'b0010, "lo_left1");
      do_move(1, 4'b0010, "lo_left2");
      do_move(2, 4'b0001, "hi_right1");
      do_move(2, 4'b0001, "hi_right2");

      // Pixel flag sweep at (20,20): columns 20..29 inside, same cycle
      for (int x = 19; x <= 31; x++) begin
         set_xy(x, 25);
         #1;
         check_val($sformatf("player_x%0d", x), int'(if_m.player), (x >= 20 && x <= 29) ? 1 : 0);
      end
      set_xy(25, 19); #1; check_val("player_y19", int'(if_m.player), 0);
      set_xy(25, 29); #1; check_val("player_y29", int'(if_m.player), 1);
      set_xy(25, 30); #1; check_val("player_y30", int'(if_m.player), 0);
      set_xy(0, 0);
      @(negedge clk);

      // game_over while PENDING: no move, frozen next cycle, stays put
      set_btn(0, 4'b0001);
      begin
         int n;
         n = 0;
         repeat (3) @(negedge clk);
         while (st(0) != 1 && n < 16) begin
            @(negedge clk);
            n++;
         end
         check_val("fz_pending", st(0), 1);
      end
      if_m.game_over = 1'b1;
      check_val("fz_not_yet", int'(if_m.frozen), 0);
      @(negedge clk);
      check_val("fz_frozen", int'(if_m.frozen), 1);
      check_val("fz_state", st(0), 2);
      set_xy(0, 480);
      repeat (12) @(negedge clk);
      check_val("fz_hold_x", px(0), mx[0]);
      check_val("fz_hold_y", py(0), my[0]);
      if_m.game_over = 1'b0;
      set_btn(0, 4'b1010);
      repeat (12) @(negedge clk);
      check_val("fz_sticky", int'(if_m.frozen), 1);
      check_val("fz_hold_x2", px(0), mx[0]);
      set_btn(0, 4'b0000);
      set_xy(0, 0);

      // Reset to clear freeze, walk to (40,60)
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      reset_models();
      check_val("unfreeze", int'(if_m.frozen), 0);
      for (int i = 0; i < 10; i++) do_move(0, 4'b0101, "walk_dr");
      for (int i = 0; i < 10; i++) do_move(0, 4'b0100, "walk_d");
      check_val("at40_x", px(0), 40);
      check_val("at60_y", py(0), 60);

      // Reset mid-PENDING
      set_btn(0, 4'b1000);
      begin
         int n;
         n = 0;
         repeat (3) @(negedge clk);
         while (st(0) != 1 && n < 16) begin
            @(negedge clk);
            n++;
         end
         check_val("rp_pending", st(0), 1);
      end
      rst = 1'b0;
      @(negedge clk);
      check_val("rp_x", px(0), 20);
      check_val("rp_y", py(0), 20);
      check_val("rp_state", st(0), 0);
      check_val("rp_frozen", int'(if_m.frozen), 0);
      check_val("rp_cnt", int'(u_dut.tick_cnt_q), 0);
      rst = 1'b1;
      set_btn(0, 4'b0000);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
